// File: rtl/ram_arbiter.sv
// Single-port work RAM arbiter: video has fixed priority, and the CPU is
// guaranteed a grant after MAX_WAIT consecutive denied cycles.
module ram_arbiter #(
    parameter int AW       = 12,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_req,
    input  logic          cpu_rw,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_gnt,
    output logic          vid_rvalid,
    output logic [DW-1:0] vid_rdata,
    output logic          ram_cs,
    output logic          ram_rw,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic {ARB, FORCE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          cpu_rvalid_q, vid_rvalid_q;
    logic          cpu_gnt_d, vid_gnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB;
            wait_cnt_q   <= '0;
            cpu_rvalid_q <= 1'b0;
            vid_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            cpu_rvalid_q <= cpu_gnt & cpu_rw;
            vid_rvalid_q <= vid_gnt;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        cpu_gnt_d  = 1'b0;
        vid_gnt_d  = 1'b0;
        case (state_q)
            ARB: begin
                if (vid_req) begin
                    vid_gnt_d = 1'b1;
                    if (cpu_req) begin
                        wait_cnt_d = wait_cnt_q + CW'(1);
                        if (wait_cnt_q == CW'(MAX_WAIT - 1)) state_d = FORCE;
                    end
                end else if (cpu_req) begin
                    cpu_gnt_d = 1'b1;
                end
            end
            FORCE: begin
                // A CPU that gave up meanwhile forfeits its slot to video.
                state_d = ARB;
                if (cpu_req) cpu_gnt_d = 1'b1;
                else         vid_gnt_d = vid_req;
            end
            default: state_d = ARB;
        endcase
        if (!cpu_req || cpu_gnt_d) wait_cnt_d = '0;
    end

    // Grants are gated by reset so no RAM command can escape while it is held.
    assign cpu_gnt   = reset_n & cpu_gnt_d;
    assign vid_gnt   = reset_n & vid_gnt_d;
    assign ram_cs    = cpu_gnt | vid_gnt;
    assign ram_rw    = cpu_gnt ? cpu_rw : 1'b1;
    assign ram_addr  = cpu_gnt ? cpu_addr : (vid_gnt ? vid_addr : '0);
    assign ram_wdata = (cpu_gnt && !cpu_rw) ? cpu_wdata : '0;

    assign cpu_rvalid = cpu_rvalid_q;
    assign vid_rvalid = vid_rvalid_q;
    assign cpu_rdata  = cpu_rvalid_q ? ram_rdata : '0;
    assign vid_rdata  = vid_rvalid_q ? ram_rdata : '0;

endmodule
